// File: rtl/cache_pkg.sv
// Shared types and helpers for the direct-mapped word cache controller.
package cache_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WB,
    FILL,
    REFILL_WR
  } state_t;

  localparam int TAG_W = 19;
  localparam int IDX_W = 11;
  localparam int OFF_W = 2;

  // Byte-lane merge of store data over the current cache word.
  function automatic logic [31:0] byte_merge(input logic [3:0]  be,
                                             input logic [31:0] wdata,
                                             input logic [31:0] rdata);
    logic [31:0] res;
    res = rdata;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) res[8*i +: 8] = wdata[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      cnt <= '0;
    end else if (inc && (cnt != {CNT_W{1'b1}})) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/cache_ctrl.sv
// Miss-handling controller for the direct-mapped word cache: zero-wait hits,
// dirty-victim writeback, refill, replay as a hit, and saturating counters.
module cache_ctrl
  import cache_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             cpu_rd,
  input  logic             cpu_wr,
  input  logic [XLEN-1:0]  cpu_addr,
  input  logic [3:0]       cpu_be,
  input  logic [XLEN-1:0]  cpu_wdata,
  output logic [XLEN-1:0]  cpu_rdata,
  output logic             cpu_ready,
  output logic [XLEN-1:0]  c_addr,
  output logic             c_we,
  output logic [XLEN-1:0]  c_wdata,
  input  logic [XLEN-1:0]  c_rdata,
  input  logic             c_hit,
  input  logic             c_dirty,
  input  logic [XLEN-1:0]  c_miss_addr,
  output logic             mem_req,
  output logic             mem_we,
  output logic [XLEN-1:0]  mem_addr,
  output logic [XLEN-1:0]  mem_wdata,
  input  logic [XLEN-1:0]  mem_rdata,
  input  logic             mem_ack,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [CNT_W-1:0] miss_cnt,
  output logic [CNT_W-1:0] wb_cnt
);

  state_t          state;
  logic [XLEN-1:0] victim;
  logic [XLEN-1:0] vdata;
  logic [XLEN-1:0] rbuf;
  logic [XLEN-1:0] line_addr;
  logic            req;
  logic            hit_now;
  logic            miss_now;
  logic            wb_done;
  logic            unused_addr_bits;

  assign req       = cpu_rd | cpu_wr;
  assign line_addr = {cpu_addr[TAG_W+IDX_W+OFF_W-1:OFF_W], {OFF_W{1'b0}}};
  assign hit_now   = (state == IDLE) && req && c_hit;
  assign miss_now  = (state == IDLE) && req && !c_hit;
  assign wb_done   = (state == WB) && mem_ack;
  assign unused_addr_bits = ^cpu_addr[OFF_W-1:0];

  // A simultaneous read and write request is served as a store.
  always_comb begin
    c_addr    = '0;
    c_we      = 1'b0;
    c_wdata   = '0;
    cpu_ready = 1'b0;
    cpu_rdata = '0;
    if (rst_b) begin
      c_addr = line_addr;
      if (hit_now) begin
        cpu_ready = 1'b1;
        if (cpu_wr) begin
          c_we    = 1'b1;
          c_wdata = byte_merge(cpu_be, cpu_wdata, c_rdata);
        end else begin
          cpu_rdata = c_rdata;
        end
      end else if (state == REFILL_WR) begin
        c_we    = 1'b1;
        c_wdata = rbuf;
      end
    end
  end

  // The memory port is a pure decode of the state, so reset drops it at once
  // and WB hands straight over to FILL without releasing mem_req.
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state)
      WB: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = victim;
        mem_wdata = vdata;
      end
      FILL: begin
        mem_req  = 1'b1;
        mem_addr = line_addr;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state  <= IDLE;
      victim <= '0;
      vdata  <= '0;
      rbuf   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (miss_now) begin
            victim <= c_miss_addr;
            vdata  <= c_rdata;
            state  <= c_dirty ? WB : FILL;
          end
        end
        WB: begin
          if (mem_ack) state <= FILL;
        end
        FILL: begin
          if (mem_ack) begin
            rbuf  <= mem_rdata;
            state <= REFILL_WR;
          end
        end
        REFILL_WR: state <= IDLE;
        default:   state <= IDLE;
      endcase
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_hit_cnt (
    .clk   (clk),
    .rst_b (rst_b),
    .inc   (hit_now),
    .cnt   (hit_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_miss_cnt (
    .clk   (clk),
    .rst_b (rst_b),
    .inc   (miss_now),
    .cnt   (miss_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_wb_cnt (
    .clk   (clk),
    .rst_b (rst_b),
    .inc   (wb_done),
    .cnt   (wb_cnt)
  );

endmodule
